gf16_mul_pipe: RTL

Parametrised, pipelined GF(2^4) multiplier array for the composite-field AES S-box datapath. Each of LANES 4-bit lanes performs three independent GF(2^4) products and one selectable unary operation (scaled square, square, or inverse). Operands enter through a valid/ready handshake, and results leave through an elastic pipeline with full backpressure support. A request tag travels alongside the data so the S-box controller can issue several rounds' nibbles back-to-back.

---
 rtl/gf16_mul_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gf16_mul_pipe.sv
// gf16_mul_pipe: LANES-wide GF(2^4) multiplier array (x^4+x+1) with an
// elastic STAGES-deep output pipeline. Each lane forms three independent
// products plus one selectable unary op on the B channel; a request tag
// rides along with the data. Control never depends on operand values.
module gf16_mul_pipe #(
    parameter int         LANES  = 16,
    parameter int         STAGES = 2,
    parameter int         TAG_W  = 4,
    parameter logic [3:0] LAMBDA = 4'hC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [4*LANES-1:0]   mul1_d1,
    input  logic [4*LANES-1:0]   mul1_d2,
    input  logic [4*LANES-1:0]   mul2_d1,
    input  logic [4*LANES-1:0]   mul2_d2,
    input  logic [4*LANES-1:0]   mul3_d1,
    input  logic [4*LANES-1:0]   mul3_d2,
    input  logic [4*LANES-1:0]   mulB_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_W-1:0]     out_tag,
    output logic [4*LANES-1:0]   mul1_out,
    output logic [4*LANES-1:0]   mul2_out,
    output logic [4*LANES-1:0]   mul3_out,
    output logic [4*LANES-1:0]   mulB_out,
    output logic                 busy,
    output logic [31:0]          txn_cnt
);

    localparam int W = 4*LANES;

    // Shift-and-add product, reducing by x^4 = x + 1 on every shift.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ {2'b00, aa[3], aa[3]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a constant table; 0 maps to 0.
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h0: r = 4'h0;  4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
            4'h4: r = 4'hD;  4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;
            4'h8: r = 4'hF;  4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;
            4'hC: r = 4'hA;  4'hD: r = 4'h4;  4'hE: r = 4'h3;  default: r = 4'h8;
        endcase
        return r;
    endfunction

    // B-channel unary op: scaled square, square, inverse, or pass-through.
    function automatic logic [3:0] gf_unary(input logic [1:0] op, input logic [3:0] a);
        logic [3:0] r;
        case (op)
            2'd0:    r = gf_mul(LAMBDA, gf_mul(a, a));
            2'd1:    r = gf_mul(a, a);
            2'd2:    r = gf_inv(a);
            default: r = a;
        endcase
        return r;
    endfunction

    logic [W-1:0]       w_m1;
    logic [W-1:0]       w_m2;
    logic [W-1:0]       w_m3;
    logic [W-1:0]       w_mb;
    logic [STAGES-1:0]  w_take;
    logic               w_acc;

    logic [STAGES-1:0]  r_vld;
    logic [W-1:0]       r_m1_p  [STAGES];
    logic [W-1:0]       r_m2_p  [STAGES];
    logic [W-1:0]       r_m3_p  [STAGES];
    logic [W-1:0]       r_mb_p  [STAGES];
    logic [TAG_W-1:0]   r_tag_p [STAGES];
    logic [31:0]        r_txn;

    // Per-lane field arithmetic on the incoming operands.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        w_m3 = '0;
        w_mb = '0;
        for (int i = 0; i < LANES; i++) begin
            w_m1[4*i +: 4] = gf_mul(mul1_d1[4*i +: 4], mul1_d2[4*i +: 4]);
            w_m2[4*i +: 4] = gf_mul(mul2_d1[4*i +: 4], mul2_d2[4*i +: 4]);
            w_m3[4*i +: 4] = gf_mul(mul3_d1[4*i +: 4], mul3_d2[4*i +: 4]);
            w_mb[4*i +: 4] = gf_unary(in_op, mulB_in[4*i +: 4]);
        end
    end

    // Stage k can load when it is empty or its content moves on; this
    // ripples back from out_ready so a full pipe still streams.
    always_comb begin
        logic t;
        w_take = '0;
        t      = out_ready;
        for (int k = STAGES-1; k >= 0; k--) begin
            w_take[k] = !r_vld[k] || t;
            t         = w_take[k];
        end
    end

    assign in_ready = w_take[0];
    assign w_acc    = in_valid && w_take[0];

    // Pipeline registers, valid bits and acceptance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_txn <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_m1_p[k]  <= '0;
                r_m2_p[k]  <= '0;
                r_m3_p[k]  <= '0;
                r_mb_p[k]  <= '0;
                r_tag_p[k] <= '0;
            end
        end else begin
            // stage 0: capture combinational results on acceptance
            if (w_acc) r_txn <= r_txn + 32'd1;
            if (w_take[0]) r_vld[0] <= w_acc;
            if (w_acc) begin
                r_m1_p[0]  <= w_m1;
                r_m2_p[0]  <= w_m2;
                r_m3_p[0]  <= w_m3;
                r_mb_p[0]  <= w_mb;
                r_tag_p[0] <= in_tag;
            end
            // stages 1..STAGES-1: advance from the previous stage
            for (int k = 1; k < STAGES; k++) begin
                if (w_take[k]) r_vld[k] <= r_vld[k-1];
                if (w_take[k] && r_vld[k-1]) begin
                    r_m1_p[k]  <= r_m1_p[k-1];
                    r_m2_p[k]  <= r_m2_p[k-1];
                    r_m3_p[k]  <= r_m3_p[k-1];
                    r_mb_p[k]  <= r_mb_p[k-1];
                    r_tag_p[k] <= r_tag_p[k-1];
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_tag   = r_tag_p[STAGES-1];
    assign mul1_out  = r_m1_p[STAGES-1];
    assign mul2_out  = r_m2_p[STAGES-1];
    assign mul3_out  = r_m3_p[STAGES-1];
    assign mulB_out  = r_mb_p[STAGES-1];
    assign busy      = |r_vld;
    assign txn_cnt   = r_txn;

endmodule
